// File: rtl/ringosc_pkg.sv
// Shared types and default parameters for the ring-oscillator frequency meter.
package ringosc_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } ringosc_state_e;

    localparam int DEFAULT_GATE_W        = 16;
    localparam int DEFAULT_CNT_W         = 16;
    localparam int DEFAULT_SETTLE_CYCLES = 16;
    localparam int DEFAULT_SYNC_STAGES   = 2;

endpackage

// File: rtl/ringosc_edge_sync.sv
// Brings the free-running oscillator output into the clk domain and turns
// each synchronised rising transition into a single-cycle pulse.
module ringosc_edge_sync
    import ringosc_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    input  logic load_prev,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_level;

    assign sync_level = sync_q[SYNC_STAGES-1];

    // Multi-flop synchroniser chain; the oldest stage is the usable level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
        end
    end

    // Previous level only follows the input while the window is being opened or is open,
    // so the first comparison in the window is against a fresh sample, never a stale one
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else if (load_prev) begin
            prev_q <= sync_level;
        end
    end

    assign rise = sync_level & ~prev_q;

endmodule

// File: rtl/ringosc_freq_meter.sv
// Gated edge counter for on-chip ring-oscillator characterisation: enables the
// oscillator, lets it settle, counts rising edges over a programmable window
// of clk cycles and holds the saturating result with a valid flag.
module ringosc_freq_meter
    import ringosc_pkg::*;
#(
    parameter int GATE_W        = DEFAULT_GATE_W,
    parameter int CNT_W         = DEFAULT_CNT_W,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              osc_in,
    output logic              osc_enable,
    output logic              busy,
    output logic              result_valid,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    COUNT_MAX   = '1;

    ringosc_state_e      state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [GATE_W-1:0]   gate_q;
    logic [GATE_W-1:0]   win_cnt;
    logic                settle_done;
    logic                window_done;
    logic                load_prev;
    logic                rise;

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign window_done = (win_cnt == gate_q - GATE_W'(1));
    assign load_prev   = ((state == SETTLE) && settle_done) || (state == MEASURE);

    ringosc_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk       (clk),
        .rst       (rst),
        .osc_in    (osc_in),
        .load_prev (load_prev),
        .rise      (rise)
    );

    // Measurement sequencer with its settle/window counters, the saturating
    // edge counter and all registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            win_cnt      <= '0;
            gate_q       <= '0;
            osc_enable   <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        gate_q       <= gate_cycles;
                        count        <= '0;
                        overflow     <= 1'b0;
                        result_valid <= 1'b0;
                        settle_cnt   <= '0;
                        busy         <= 1'b1;
                        osc_enable   <= 1'b1;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_done) begin
                        win_cnt <= '0;
                        if (gate_q != '0) begin
                            state <= MEASURE;
                        end else begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            osc_enable   <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        if (count == COUNT_MAX) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    if (window_done) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        osc_enable   <= 1'b0;
                        result_valid <= 1'b1;
                    end else begin
                        win_cnt <= win_cnt + GATE_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Self-checking bench for ringosc_freq_meter: a default-width instance and a
// 4-bit-count instance, with measurements checked against a sample-history model.
module tb_ringosc_freq_meter;

    localparam int SETTLE = 16;
    localparam int SYNC   = 2;
    localparam int HIST   = 32768;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        use4 = 1'b0;
    logic [15:0] gate_cycles = '0;
    logic        osc_in = 1'b0;

    logic        start_a, start_b;
    logic        osc_enable_a, busy_a, valid_a, ovf_a;
    logic [15:0] count_a;
    logic        osc_enable_b, busy_b, valid_b, ovf_b;
    logic [3:0]  count_b;

    int cyc = 0;
    int osc_mode = 0;
    bit hist [HIST];
    int checks = 0;
    int errors = 0;

    assign start_a = start & ~use4;
    assign start_b = start & use4;

    ringosc_freq_meter #(
        .GATE_W(16), .CNT_W(16), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .start(start_a), .gate_cycles(gate_cycles),
        .osc_in(osc_in), .osc_enable(osc_enable_a), .busy(busy_a),
        .result_valid(valid_a), .count(count_a), .overflow(ovf_a)
    );

    ringosc_freq_meter #(
        .GATE_W(16), .CNT_W(4), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)
    ) dut4 (
        .clk(clk), .rst(rst), .start(start_b), .gate_cycles(gate_cycles),
        .osc_in(osc_in), .osc_enable(osc_enable_b), .busy(busy_b),
        .result_valid(valid_b), .count(count_b), .overflow(ovf_b)
    );

    // System clock
    always #5 clk = ~clk;

    // Cycle index: between posedges the current cycle number is cyc
    always @(posedge clk) cyc = cyc + 1;

    // Oscillator stand-in: 0 = stopped, 1 = clk/2, 2 = clk/4, 3 = random level
    always @(negedge clk) begin
        case (osc_mode)
            1:       osc_in = ~osc_in;
            2:       osc_in = ((cyc >> 1) & 1) != 0;
            3:       osc_in = ($urandom % 2) != 0;
            default: osc_in = 1'b0;
        endcase
        hist[cyc % HIST] = osc_in;
    end

    // Rising edges whose detection, delayed SYNC cycles, lands in window cycles SETTLE+1..SETTLE+g
    function automatic int model_edges(input int s_cyc, input int g);
        int raw = 0;
        for (int c = SETTLE + 1; c <= SETTLE + g; c++) begin
            int i = s_cyc + c - SYNC;
            if (hist[i % HIST] && !hist[(i - 1) % HIST]) raw++;
        end
        return raw;
    endfunction

    task automatic measure_once(input int g, input int mode, input bit sel4,
                                input int disturb, input string tag);
        int s_cyc, raw, max_cnt, exp_cnt;
        logic [2:0]  exp_ctl, got_ctl;
        logic [15:0] got_cnt;
        logic        got_ovf, exp_ovf;
        use4 = sel4;
        osc_mode = mode;
        gate_cycles = 16'(g);
        start = 1'b1;
        s_cyc = cyc;
        max_cnt = sel4 ? 15 : 65535;
        for (int k = 1; k <= SETTLE + g + 1; k++) begin
            @(negedge clk);
            start = (k == disturb);
            if (k == disturb) gate_cycles = 16'($urandom_range(1, 200));
            exp_ctl = {k <= SETTLE + g, k <= SETTLE + g, k == SETTLE + g + 1};
            got_ctl = use4 ? {osc_enable_b, busy_b, valid_b} : {osc_enable_a, busy_a, valid_a};
            checks++;
            if (got_ctl !== exp_ctl) begin
                errors++;
                $display("[TB] FAIL %s_ctl cycle %0d: {osc_enable,busy,valid} got %b expected %b",
                         tag, k, got_ctl, exp_ctl);
            end
        end
        raw = model_edges(s_cyc, g);
        exp_cnt = (raw > max_cnt) ? max_cnt : raw;
        exp_ovf = (raw > max_cnt);
        got_cnt = use4 ? {12'b0, count_b} : count_a;
        got_ovf = use4 ? ovf_b : ovf_a;
        checks++;
        if (got_cnt !== 16'(exp_cnt)) begin
            errors++;
            $display("[TB] FAIL %s_count: got %0d expected %0d", tag, got_cnt, exp_cnt);
        end
        checks++;
        if (got_ovf !== exp_ovf) begin
            errors++;
            $display("[TB] FAIL %s_overflow: got %b expected %b", tag, got_ovf, exp_ovf);
        end
    endtask

    task automatic test_reset();
        osc_mode = 3;
        repeat (3) @(negedge clk);
        checks++;
        if ({osc_enable_a, busy_a, valid_a, ovf_a, count_a, osc_enable_b, busy_b, valid_b, ovf_b, count_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held: outputs a=%b%b%b%b/%0d b=%b%b%b%b/%0d expected all 0",
                     osc_enable_a, busy_a, valid_a, ovf_a, count_a, osc_enable_b, busy_b, valid_b, ovf_b, count_b);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({osc_enable_a, busy_a, valid_a, ovf_a, count_a, osc_enable_b, busy_b, valid_b, ovf_b, count_b} !== '0) begin
                errors++;
                $display("[TB] FAIL idle_outputs cycle %0d: a=%b%b%b%b/%0d b=%b%b%b%b/%0d expected all 0",
                         i, osc_enable_a, busy_a, valid_a, ovf_a, count_a, osc_enable_b, busy_b, valid_b, ovf_b, count_b);
            end
        end
    endtask

    task automatic test_clk4_window();
        measure_once(100, 2, 1'b0, 0, "clk4");
        checks++;
        if (count_a < 16'd24 || count_a > 16'd26) begin
            errors++;
            $display("[TB] FAIL clk4_band: got %0d expected 25 +/- 1", count_a);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        measure_once(64, 1, 1'b1, 0, "ovf4");
        checks++;
        if (count_b !== 4'd15 || ovf_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf4_saturate: got count %0d overflow %b expected 15 / 1", count_b, ovf_b);
        end
        @(negedge clk);
    endtask

    task automatic test_gate_zero();
        measure_once(0, 3, 1'b0, 0, "gate0");
        checks++;
        if (count_a !== 16'd0) begin
            errors++;
            $display("[TB] FAIL gate0_zero: got %0d expected 0", count_a);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        measure_once(50, 3, 1'b0, SETTLE + 20, "nostart");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        measure_once(1, 2, 1'b0, 0, "gate1");
        for (int r = 0; r < 4; r++) begin
            measure_once(int'($urandom_range(1, 40)), int'($urandom_range(0, 3)), 1'b0, 0, "b2b");
        end
        @(negedge clk);
        measure_once(int'($urandom_range(1, 40)), 3, 1'b1, 0, "rand4");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_measure();
        use4 = 1'b0;
        osc_mode = 3;
        gate_cycles = 16'd80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 9) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_busy: got %b expected 1", busy_a);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({osc_enable_a, busy_a, valid_a, ovf_a, count_a} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_clear: got %b%b%b%b/%0d expected all 0",
                     osc_enable_a, busy_a, valid_a, ovf_a, count_a);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({osc_enable_a, busy_a, valid_a, ovf_a, count_a} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_idle: got %b%b%b%b/%0d expected all 0",
                     osc_enable_a, busy_a, valid_a, ovf_a, count_a);
        end
        measure_once(30, 2, 1'b0, 0, "after_rst");
        @(negedge clk);
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] ringosc_freq_meter bench start");
        test_reset();
        test_clk4_window();
        test_overflow();
        test_gate_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_measure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
